// File: rtl/case_1_sdiv_5s_4s_5_seq.sv
// case_1_sdiv_5s_4s_5_seq
// Multi-cycle signed divider: din0 / din1 with C semantics (quotient
// truncated toward zero, remainder takes the sign of the dividend).
// Restoring division on operand magnitudes, one quotient bit per clock,
// followed by a sign fix-up cycle. ap_* block-level handshake.
//
// Ports:
//   ap_clk      clock, rising edge
//   ap_rst      asynchronous active-high reset
//   ap_start    request, sampled only in IDLE
//   ap_ready    operands captured this cycle (ap_start while IDLE)
//   ap_idle     block is in IDLE
//   ap_done     one-cycle pulse, dout/rem valid
//   din0        signed dividend
//   din1        signed divisor
//   dout        signed quotient, registered
//   rem         signed remainder, registered
//   div_by_zero only with CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN defined:
//               registered flag, 1 when the last result had a zero divisor
//
// Optional feature macro: CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for ap_start; operands captured on the start edge
// CALC  | one restoring step per cycle, dividend MSB first
// FIX   | sign fix-up, results registered into dout/rem
// DONE  | ap_done pulse, returns to IDLE

module case_1_sdiv_5s_4s_5_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 5,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem
`ifdef CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
    ,
    output logic                  div_by_zero
`endif
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(W0 + 1);

    // Reject configurations the datapath cannot represent.
    if (dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
        $error("case_1_sdiv_5s_4s_5_seq: dout_WIDTH must equal din0_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    // Magnitudes carry one extra bit so the most negative operand fits.
    logic [W0:0]     amag_q, amag_d;
    logic [W1:0]     bmag_q, bmag_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic [W1-1:0]   d0lo_q, d0lo_d;
    logic [W1-1:0]   prem_q, prem_d;
    logic [W0-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W0-1:0]   dout_q, dout_d;
    logic [W1-1:0]   rem_q, rem_d;
    logic            dz_q, dz_d;

    logic [W0:0]     a_ext;
    logic [W1:0]     b_ext;
    logic [W1:0]     trial;
    logic            div_zero;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            amag_q  <= '0;
            bmag_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            d0lo_q  <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            amag_q  <= amag_d;
            bmag_q  <= bmag_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            d0lo_q  <= d0lo_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        amag_d   = amag_q;
        bmag_d   = bmag_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        d0lo_d   = d0lo_q;
        prem_d   = prem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        a_ext    = {din0[W0-1], din0};
        b_ext    = {din1[W1-1], din1};
        trial    = {prem_q, amag_q[cnt_q]};
        div_zero = (bmag_q == '0);

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    amag_d  = a_ext[W0] ? (~a_ext + 1'b1) : a_ext;
                    bmag_d  = b_ext[W1] ? (~b_ext + 1'b1) : b_ext;
                    s0_d    = din0[W0-1];
                    s1_d    = din1[W1-1];
                    // Raw low dividend bits form the divide-by-zero remainder.
                    d0lo_d  = din0[W1-1:0];
                    prem_d  = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(W0 - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // The remainder is always below |divisor| <= 2^(W1-1), so it
                // never needs more than W1 bits after the subtract.
                if (trial >= bmag_q) begin
                    prem_d = W1'(trial - bmag_q);
                    quo_d  = {quo_q[W0-2:0], 1'b1};
                end else begin
                    prem_d = trial[W1-1:0];
                    quo_d  = {quo_q[W0-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div_zero) begin
                    dout_d = '1;
                    rem_d  = d0lo_q;
                end else begin
                    dout_d = (s0_q ^ s1_q) ? (~quo_q + 1'b1) : quo_q;
                    rem_d  = s0_q ? (~prem_q + 1'b1) : prem_q;
                end
                dz_d    = div_zero;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ap_idle  = (state_q == S_IDLE);
    assign ap_ready = (state_q == S_IDLE) && ap_start;
    assign ap_done  = (state_q == S_DONE);
    assign dout     = dout_q;
    assign rem      = rem_q;

`ifdef CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
    assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_case_1_sdiv_5s_4s_5_seq.sv
module tb_case_1_sdiv_5s_4s_5_seq;

    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic       ap_start;
    logic       ap_ready;
    logic       ap_idle;
    logic       ap_done;
    logic [4:0] din0;
    logic [3:0] din1;
    logic [4:0] dout;
    logic [3:0] rem;
`ifdef CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
    logic       div_by_zero;
`endif

    case_1_sdiv_5s_4s_5_seq #(
        .ID(1), .din0_WIDTH(5), .din1_WIDTH(4), .dout_WIDTH(5)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .rem      (rem)
`ifdef CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [4:0] q;
        logic [3:0] r;
        logic       dz;
        int         cyc;
        int         a;
        int         b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_cap = 0;
    bit   last_hold = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // C-style signed division: truncation toward zero, remainder follows
    // the dividend; divide by zero yields all-ones and the raw dividend bits.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q  = 5'h1F;
            e.r  = 4'(a);
            e.dz = 1'b1;
        end else begin
            e.q  = 5'(a / b);
            e.r  = 4'(a % b);
            e.dz = 1'b0;
        end
        e.a   = a;
        e.b   = b;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every ap_done must match the oldest outstanding request.
    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst && ap_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'b0, ap_done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("dout %0d/%0d", e.a, e.b), {27'b0, dout}, {27'b0, e.q});
                chk($sformatf("rem %0d/%0d", e.a, e.b), {28'b0, rem}, {28'b0, e.r});
                chk("latency", cyc - e.cyc, 32'd7);
                chk("idle_at_done", {31'b0, ap_idle}, 32'd0);
`ifdef CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
                chk($sformatf("dz %0d/%0d", e.a, e.b), {31'b0, div_by_zero}, {31'b0, e.dz});
`endif
            end
        end
    end

    // Called just after a negedge; returns just after a negedge.
    task automatic issue(input int a, input int b, input bit hold);
        exp_t e;
        int   n;
        n        = 0;
        din0     = 5'(a);
        din1     = 4'(b);
        ap_start = 1'b1;
        #1;
        while (!ap_ready && n < 40) begin
            @(negedge ap_clk);
            #1;
            n++;
        end
        if (!ap_ready) begin
            chk("start_timeout", {31'b0, ap_ready}, 32'd1);
        end else begin
            e     = model(a, b);
            e.cyc = cyc;
            sb.push_back(e);
            if (hold && last_hold) chk("interval", cyc - last_cap, 32'd8);
            last_cap  = cyc;
            last_hold = hold;
            @(posedge ap_clk);
            #1;
            if (!hold) ap_start = 1'b0;
            // Operands must not matter once captured.
            din0 = 5'($urandom);
            din1 = 4'($urandom);
        end
        @(negedge ap_clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    int dir_a[7] = '{13, -13, 7, -8, -16, 5, 6};
    int dir_b[7] = '{3, 3, -2, -3, -1, 0, 2};

    initial begin
        logic [4:0] ra;
        logic [3:0] rb;
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_idle", {31'b0, ap_idle}, 32'd1);
        chk("rst_done", {31'b0, ap_done}, 32'd0);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("post_rst_idle", {31'b0, ap_idle}, 32'd1);
        chk("post_rst_done", {31'b0, ap_done}, 32'd0);
        chk("post_rst_ready", {31'b0, ap_ready}, 32'd0);
        chk("post_rst_dout", {27'b0, dout}, 32'd0);
        chk("post_rst_rem", {28'b0, rem}, 32'd0);

        for (int i = 0; i < 7; i++) issue(dir_a[i], dir_b[i], 1'b0);
        drain();

        for (int i = 0; i < 60; i++) begin
            ra = 5'($urandom);
            rb = 4'($urandom);
            issue(int'($signed(ra)), int'($signed(rb)), 1'b0);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge ap_clk);
        end
        drain();

        for (int i = 0; i < 12; i++) begin
            ra = 5'($urandom);
            rb = 4'($urandom);
            issue(int'($signed(ra)), int'($signed(rb)), 1'b1);
        end
        ap_start  = 1'b0;
        last_hold = 1'b0;
        drain();

        // Abort a division in flight: no ap_done, everything back to reset.
        issue(9, 2, 1'b0);
        repeat (2) @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_idle", {31'b0, ap_idle}, 32'd1);
        chk("midrst_done", {31'b0, ap_done}, 32'd0);
        chk("midrst_dout", {27'b0, dout}, 32'd0);
        chk("midrst_rem", {28'b0, rem}, 32'd0);
`ifdef CASE_1_SDIV_DIV_BY_ZERO_FLAG_EN
        chk("midrst_dz", {31'b0, div_by_zero}, 32'd0);
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (12) @(negedge ap_clk);
        chk("after_abort_idle", {31'b0, ap_idle}, 32'd1);
        chk("after_abort_dout", {27'b0, dout}, 32'd0);

        issue(13, 3, 1'b0);
        issue(-16, -1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
